reg_dump: RTL
=============

REG_DUMP -- requirements
Module: reg_dump

Interface
REQ-001 Parameter DATA_W, default 16, width of each register value and of out_data.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 start  input  1  request to begin a dump; sampled only in IDLE.
REQ-005 first_sel  input  4  index of first register to emit; captured on accepted start.
REQ-006 last_sel  input  4  index of last register to emit; captured on accepted start.
REQ-007 reg0..reg15  input  DATA_W each  current register-file contents, one port per register.
REQ-008 out_valid  output  1  out_sel/out_data hold a valid item.
REQ-009 out_ready  input  1  consumer accepts item; transfer = out_valid && out_ready at rising edge.
REQ-010 out_sel  output  4  index of the register being emitted.
REQ-011 out_data  output  DATA_W  value of that register.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse after the final transfer.

Function
REQ-014 FSM states SHALL be IDLE, SEND, DONE.
REQ-015 IDLE: start=1 SHALL capture first_sel/last_sel, load index=first_sel, go to SEND; start=0 stays IDLE.
REQ-016 Latency: start sampled at edge N SHALL give out_valid=1 with out_sel=first_sel after edge N, i.e. valid from cycle N+1.
REQ-017 out_data SHALL be snapshot of reg[index] registered on the same edge that loads index; it SHALL NOT track register changes while the item is held.
REQ-018 While out_valid=1 and out_ready=0, out_sel and out_data SHALL remain stable.
REQ-019 On transfer with index != last, index SHALL increment modulo 16 and new snapshot load on the same edge; out_valid stays 1 (one item per cycle, no bubble).
REQ-020 Wrap-around: last_sel < first_sel SHALL emit first_sel..15 then 0..last_sel; first_sel == last_sel emits exactly one item; full range (first=0,last=15 or first=k,last=k-1) emits 16 items.
REQ-021 On transfer with index == last, SHALL go to DONE with out_valid=0 next cycle.
REQ-022 DONE SHALL assert done=1 for exactly one cycle, then return to IDLE unconditionally.
REQ-023 start while in SEND or DONE SHALL be ignored (no restart, no queuing).
REQ-024 Changes to first_sel/last_sel after acceptance SHALL NOT affect the running dump.
REQ-025 Item count per dump SHALL be ((last_sel - first_sel) mod 16) + 1.

Reset
REQ-026 reset=1 at a rising edge SHALL force IDLE, out_valid=0, done=0, busy=0, out_sel=0, out_data=0, from any state, including mid-dump; reset dominates start and out_ready.
REQ-027 No item SHALL be emitted after a reset until a new start is accepted.

Verification
REQ-028 reg_k=16'h1000+k, start with first=2,last=5, out_ready=1 -> items (2,1002),(3,1003),(4,1004),(5,1005) on 4 consecutive cycles, then done pulse 1 cycle, busy low after.
REQ-029 first=14,last=1, out_ready=1 -> out_sel sequence 14,15,0,1, then done.
REQ-030 first=3,last=3, out_ready held 0 for 5 cycles then 1 -> out_valid=1, out_sel=3, out_data stable for 5 cycles even if reg3 changes to 16'hBEEF; single transfer of original value; done.
REQ-031 first=0,last=15, out_ready toggling 1,0,1,0 -> exactly 16 transfers, indices 0..15 in order, no duplicates or skips.
REQ-032 reset=1 during third item of a 2..9 dump -> next cycle out_valid=0,busy=0,done=0; start pulsed during that dump before reset had no effect; new start afterwards begins at its own first_sel.
REQ-033 start held high continuously -> dump completes, done pulses, IDLE one cycle, then new dump begins (no restart mid-dump).

Source files
------------

// File: rtl/reg_dump.sv
// reg_dump -- streams a contiguous (wrapping) range of a 16-entry register
// file out over a valid/ready interface, one item per cycle.
//
// A dump is requested with start_i while idle. The first and last indices are
// captured at that moment, so later changes on first_sel_i/last_sel_i do not
// disturb a running dump. Each emitted value is a snapshot taken on the edge
// that loads its index; it stays frozen while the consumer stalls.
//
// Ports
//   clk_i          single clock, rising edge
//   reset_i        synchronous active-high reset
//   start_i        begin a dump (only honoured in IDLE)
//   first_sel_i    index of the first register to emit
//   last_sel_i     index of the last register to emit (may wrap below first)
//   reg0_i..15_i   live register-file contents
//   out_valid_o    out_sel_o/out_data_o hold an item
//   out_ready_i    consumer accepts the item this cycle
//   out_sel_o      index of the item being emitted
//   out_data_o     snapshot of that register
//   busy_o         high whenever not IDLE
//   done_o         one-cycle pulse after the final transfer
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start_i
// SEND  | presenting item idx_q, advancing on each accepted transfer
// DONE  | final item taken; pulse done_o, then back to IDLE

module reg_dump #(
    parameter int DATA_W = 16
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [3:0]        first_sel_i,
    input  logic [3:0]        last_sel_i,
    input  logic [DATA_W-1:0] reg0_i,
    input  logic [DATA_W-1:0] reg1_i,
    input  logic [DATA_W-1:0] reg2_i,
    input  logic [DATA_W-1:0] reg3_i,
    input  logic [DATA_W-1:0] reg4_i,
    input  logic [DATA_W-1:0] reg5_i,
    input  logic [DATA_W-1:0] reg6_i,
    input  logic [DATA_W-1:0] reg7_i,
    input  logic [DATA_W-1:0] reg8_i,
    input  logic [DATA_W-1:0] reg9_i,
    input  logic [DATA_W-1:0] reg10_i,
    input  logic [DATA_W-1:0] reg11_i,
    input  logic [DATA_W-1:0] reg12_i,
    input  logic [DATA_W-1:0] reg13_i,
    input  logic [DATA_W-1:0] reg14_i,
    input  logic [DATA_W-1:0] reg15_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [3:0]        out_sel_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic              busy_o,
    output logic              done_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        idx_q, idx_d;
    logic [3:0]        last_q, last_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [3:0]        idx_inc;

    logic [DATA_W-1:0] regs [16];

    assign regs[0]  = reg0_i;
    assign regs[1]  = reg1_i;
    assign regs[2]  = reg2_i;
    assign regs[3]  = reg3_i;
    assign regs[4]  = reg4_i;
    assign regs[5]  = reg5_i;
    assign regs[6]  = reg6_i;
    assign regs[7]  = reg7_i;
    assign regs[8]  = reg8_i;
    assign regs[9]  = reg9_i;
    assign regs[10] = reg10_i;
    assign regs[11] = reg11_i;
    assign regs[12] = reg12_i;
    assign regs[13] = reg13_i;
    assign regs[14] = reg14_i;
    assign regs[15] = reg15_i;

    // 4-bit add wraps 15 -> 0, which gives the modulo-16 walk for free.
    assign idx_inc = idx_q + 4'd1;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_SEND;
                    idx_d   = first_sel_i;
                    last_d  = last_sel_i;
                    data_d  = regs[first_sel_i];
                end
            end
            S_SEND: begin
                if (out_ready_i) begin
                    if (idx_q == last_q) begin
                        state_d = S_DONE;
                    end else begin
                        // Reload index and snapshot together: no bubble.
                        idx_d  = idx_inc;
                        data_d = regs[idx_inc];
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            idx_q   <= 4'd0;
            last_q  <= 4'd0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            data_q  <= data_d;
        end
    end

    assign out_valid_o = (state_q == S_SEND);
    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = (state_q == S_DONE);
    assign out_sel_o   = idx_q;
    assign out_data_o  = data_q;

endmodule
